// File: rtl/mem_system_param.sv
// Parametrised single-port memory subsystem: source muxing, hardware zero-fill,
// out-of-range fault detection and, when MEM_IO_EN is defined, one memory-mapped I/O word.
module mem_system_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 14,
  parameter int N_ADDR     = 4,
  parameter int N_DATA     = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_ADDR*ADDR_W-1:0]   addr_in,
  input  logic [N_DATA*DATA_W-1:0]   data_in,
  input  logic [$clog2(N_ADDR)-1:0]  mem_addr,
  input  logic [$clog2(N_DATA)-1:0]  mem_data,
  input  logic                       mem_write,
  input  logic                       mem_read,
  input  logic [DATA_W-1:0]          io_in,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic                       busy,
  output logic                       fault,
  output logic [DATA_W-1:0]          io_out
);

  localparam int SEL_A_W = $clog2(N_ADDR);
  localparam int SEL_D_W = $clog2(N_DATA);
  localparam int A_SLOTS = 1 << SEL_A_W;
  localparam int D_SLOTS = 1 << SEL_D_W;
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_reg;
  logic [DEPTH_LOG2-1:0]   fill_cnt_reg;
  logic                    busy_reg;
  logic                    rd_pend_reg;
  logic                    rd_zero_reg;
  logic                    fault_pend_reg;
  logic [DATA_W-1:0]       read_data_reg;
  logic                    read_valid_reg;
  logic                    fault_reg;
  logic [DATA_W-1:0]       ram_q_reg;
  logic [DATA_W-1:0]       rd_word;

  logic [ADDR_W-1:0]       addr_tab [A_SLOTS];
  logic [DATA_W-1:0]       data_tab [D_SLOTS];
  logic [ADDR_W-1:0]       addr_sel;
  logic [DATA_W-1:0]       data_sel;
  logic                    in_range;
  logic                    is_io;
  logic                    clearing;
  logic                    ready;
  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_idx;
  logic [DATA_W-1:0]       ram_wdata;

  logic [DATA_W-1:0]       ram [DEPTH];

  // Select codes beyond the populated sources fall back to source 0.
  generate
    for (genvar gi = 0; gi < A_SLOTS; gi++) begin : g_addr_tab
      if (gi < N_ADDR) begin : g_src
        assign addr_tab[gi] = addr_in[gi*ADDR_W +: ADDR_W];
      end else begin : g_dflt
        assign addr_tab[gi] = addr_in[ADDR_W-1:0];
      end
    end
    for (genvar gi = 0; gi < D_SLOTS; gi++) begin : g_data_tab
      if (gi < N_DATA) begin : g_src
        assign data_tab[gi] = data_in[gi*DATA_W +: DATA_W];
      end else begin : g_dflt
        assign data_tab[gi] = data_in[DATA_W-1:0];
      end
    end
  endgenerate

  assign addr_sel = addr_tab[mem_addr];
  assign data_sel = data_tab[mem_data];

  generate
    if (DEPTH_LOG2 < ADDR_W) begin : g_range
      assign in_range = (addr_sel[ADDR_W-1:DEPTH_LOG2] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

`ifdef MEM_IO_EN
  assign is_io = &addr_sel;
`else
  assign is_io = 1'b0;
`endif

  assign clearing  = (state_reg == CLEAR);
  assign ready     = (state_reg == READY);
  assign ram_we    = !RST && (clearing || (ready && mem_write && in_range && !is_io));
  assign ram_idx   = clearing ? fill_cnt_reg : addr_sel[DEPTH_LOG2-1:0];
  assign ram_wdata = clearing ? '0 : data_sel;

  // Write-first single-port RAM with registered read; no reset so it maps to block RAM.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram[ram_idx] <= ram_wdata;
      ram_q_reg    <= ram_wdata;
    end else begin
      ram_q_reg    <= ram[ram_idx];
    end
  end

`ifdef MEM_IO_EN
  logic              rd_io_reg;
  logic              io_wr_reg;
  logic [DATA_W-1:0] io_wdata_reg;
  logic [DATA_W-1:0] io_in_reg;
  logic [DATA_W-1:0] io_out_reg;

  // io_in is captured on the request edge so the returned word matches that instant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_io_reg    <= 1'b0;
      io_wr_reg    <= 1'b0;
      io_wdata_reg <= '0;
      io_in_reg    <= '0;
      io_out_reg   <= '0;
    end else begin
      rd_io_reg <= 1'b0;
      io_wr_reg <= 1'b0;
      if (io_wr_reg) begin
        io_out_reg <= io_wdata_reg;
      end
      if (ready) begin
        rd_io_reg    <= mem_read && is_io;
        io_wr_reg    <= mem_write && is_io;
        io_wdata_reg <= data_sel;
        io_in_reg    <= io_in;
      end
    end
  end

  assign io_out = io_out_reg;
`else
  logic unused_io;
  assign unused_io = ^io_in;
  assign io_out    = '0;
`endif

  always_comb begin
    rd_word = rd_zero_reg ? '0 : ram_q_reg;
`ifdef MEM_IO_EN
    if (rd_io_reg) begin
      rd_word = io_in_reg;
    end
`endif
  end

  // Control FSM: requests are sampled into a one-deep stage, results land on the next edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= CLEAR;
      fill_cnt_reg   <= '0;
      busy_reg       <= 1'b1;
      rd_pend_reg    <= 1'b0;
      rd_zero_reg    <= 1'b0;
      fault_pend_reg <= 1'b0;
      read_data_reg  <= '0;
      read_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      read_valid_reg <= rd_pend_reg;
      if (rd_pend_reg) begin
        read_data_reg <= rd_word;
      end
      if (fault_pend_reg) begin
        fault_reg <= 1'b1;
      end
      rd_pend_reg    <= 1'b0;
      fault_pend_reg <= 1'b0;
      case (state_reg)
        CLEAR: begin
          fill_cnt_reg <= fill_cnt_reg + 1'b1;
          if (fill_cnt_reg == '1) begin
            state_reg <= READY;
            busy_reg  <= 1'b0;
          end
        end
        READY: begin
          rd_pend_reg    <= mem_read;
          rd_zero_reg    <= !in_range && !is_io;
          fault_pend_reg <= (mem_read || mem_write) && !in_range && !is_io;
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  assign read_data  = read_data_reg;
  assign read_valid = read_valid_reg;
  assign busy       = busy_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_mem_system_param.sv
// Directed bench for mem_system_param (DEPTH_LOG2=4) with a read-result scoreboard.
module tb_mem_system_param;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DL = 4;
  localparam int NA = 4;
  localparam int ND = 2;
  localparam int DEPTH = 16;
`ifdef MEM_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NA*AW-1:0]  addr_in = '0;
  logic [ND*DW-1:0]  data_in = '0;
  logic [1:0]        mem_addr = '0;
  logic [0:0]        mem_data = '0;
  logic              mem_write = 1'b0;
  logic              mem_read = 1'b0;
  logic [DW-1:0]     io_in = '0;
  logic [DW-1:0]     read_data;
  logic              read_valid;
  logic              busy;
  logic              fault;
  logic [DW-1:0]     io_out;

  mem_system_param #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .N_ADDR(NA), .N_DATA(ND)
  ) dut (
    .CLK(clk), .RST(rst), .addr_in(addr_in), .data_in(data_in),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .mem_read(mem_read), .io_in(io_in), .read_data(read_data),
    .read_valid(read_valid), .busy(busy), .fault(fault), .io_out(io_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    string         tag;
  } sb_t;
  sb_t sb[$];

  logic [DW-1:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Results are due two edges after the driving negedge: sample edge, then result edge.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check({e.tag, " read_valid"}, read_valid, 1'b1);
      check({e.tag, " read_data"}, read_data, e.data);
      $display("[%0d] read %s: data=0x%04h expected=0x%04h valid=%0b",
               cyc, e.tag, read_data, e.data, read_valid);
    end else if (read_valid) begin
      check("unexpected read_valid", read_valid, 1'b0);
    end
  end

  task automatic push_exp(input logic [DW-1:0] d, input string tag);
    sb.push_back('{data: d, due: cyc + 2, tag: tag});
  endtask

  // One request through address/data source 0; model updated before the read (write-first).
  task automatic req(input logic rd, input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input string tag);
    logic inr;
    logic io;
    logic [DW-1:0] e;
    logic [DL-1:0] idx;
    inr = (a < DEPTH);
    io  = IO_EN && (a == 16'hFFFF);
    idx = a[DL-1:0];
    addr_in[AW-1:0] = a;
    data_in[DW-1:0] = wd;
    mem_addr = 2'd0;
    mem_data = 1'b0;
    mem_read = rd;
    mem_write = wr;
    if (wr && inr && !io) model[idx] = wd;
    e = io ? io_in : (inr ? model[idx] : '0);
    if (rd) push_exp(e, tag);
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin : stim
    int n;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    check("reset read_data", read_data, 16'h0000);
    check("reset read_valid", read_valid, 1'b0);
    check("reset busy", busy, 1'b1);
    check("reset fault", fault, 1'b0);
    check("reset io_out", io_out, 16'h0000);

    rst = 1'b0;
    count_busy(n);
    check("zero-fill busy cycles", n, 16);
    for (int i = 0; i < DEPTH; i++) req(1'b1, 1'b0, 16'(i), 16'h0, $sformatf("fill[%0d]", i));
    drain();

    // Source select: sources hold 3/5/7/9
    addr_in = {16'd9, 16'd7, 16'd5, 16'd3};
    data_in = {16'hBEEF, 16'h1234};
    mem_addr = 2'd2; mem_data = 1'b1; mem_write = 1'b1;
    model[7] = 16'hBEEF;
    @(negedge clk);
    mem_write = 1'b0;
    mem_read = 1'b1; push_exp(16'hBEEF, "src2 addr7");
    @(negedge clk);
    mem_addr = 2'd1; push_exp(16'h0000, "src1 addr5");
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; mem_data = 1'b0; mem_addr = 2'd3;
    model[9] = 16'h1234;
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1; push_exp(16'h1234, "src3 addr9");
    @(negedge clk);
    mem_read = 1'b0;
    drain();

    req(1'b0, 1'b1, 16'd3, 16'h1111, "wr3");
    req(1'b1, 1'b1, 16'd3, 16'h2222, "collide3");
    req(1'b1, 1'b0, 16'd3, 16'h0, "after collide3");
    drain();

    // I/O word at the all-ones address
    check("fault before io", fault, 1'b0);
    req(1'b0, 1'b1, 16'hFFFF, 16'h00C3, "io wr");
    @(negedge clk);
    check("io_out after write", io_out, IO_EN ? 16'h00C3 : 16'h0000);
    check("fault after io write", fault, IO_EN ? 1'b0 : 1'b1);
    io_in = 16'h1234;
    req(1'b1, 1'b0, 16'hFFFF, 16'h0, "io rd");
    io_in = 16'h0000;
    req(1'b1, 1'b0, 16'd15, 16'h0, "addr15 untouched");
    drain();
    check("fault after io read", fault, IO_EN ? 1'b0 : 1'b1);

    // Mid-fill reset with RAM preloaded and a read pending
    for (int i = 0; i < DEPTH; i++) req(1'b0, 1'b1, 16'(i), 16'h5555, "preload");
    req(1'b1, 1'b0, 16'd4, 16'h0, "dropped");
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    check("rst read_valid dropped", read_valid, 1'b0);
    check("rst clears fault", fault, 1'b0);
    check("rst clears io_out", io_out, 16'h0000);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("busy at fill_cnt 8", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr_in[AW-1:0] = 16'd2; mem_read = 1'b1; mem_write = 1'b1;
    count_busy(n);
    mem_read = 1'b0; mem_write = 1'b0;
    check("refill busy cycles", n, 16);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) req(1'b1, 1'b0, 16'(i), 16'h0, $sformatf("refill[%0d]", i));
    drain();

    // Out-of-range access
    req(1'b0, 1'b1, 16'd0, 16'h0BAD, "wr0");
    req(1'b0, 1'b1, 16'h0010, 16'hAAAA, "oob wr");
    check("fault one edge after sample", fault, 1'b0);
    @(negedge clk);
    check("fault after oob write", fault, 1'b1);
    req(1'b1, 1'b0, 16'd0, 16'h0, "addr0 unchanged");
    req(1'b1, 1'b0, 16'h0010, 16'h0, "oob rd");
    drain();
    repeat (5) @(negedge clk);
    check("fault sticky", fault, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("fault cleared by rst", fault, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_system_param.md
# mem_system_param

Parametrised single-port data/instruction memory subsystem for the processor datapath. Selects one of N_ADDR address sources and one of N_DATA write-data sources, performs a registered read or write against an internal inferred RAM, and reports completion with a read-valid strobe. Adds hardware zero-fill after reset, out-of-range fault detection and an optional memory-mapped I/O register.

## Interface
Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 16, address width of each source
- DEPTH_LOG2, 14, log2 of RAM depth in words; requires DEPTH_LOG2 <= ADDR_W
- N_ADDR, 4, number of address sources; must be at least 2
- N_DATA, 2, number of write-data sources; must be at least 2

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- addr_in  in  N_ADDR*ADDR_W  packed address sources; source k is bits [k*ADDR_W +: ADDR_W]
- data_in  in  N_DATA*DATA_W  packed write-data sources, same packing
- mem_addr  in  $clog2(N_ADDR)  address source select
- mem_data  in  $clog2(N_DATA)  write-data source select
- mem_write  in  1  write request, sampled per cycle
- mem_read  in  1  read request, sampled per cycle
- io_in  in  DATA_W  external input word, readable at the I/O address
- read_data  out  DATA_W  registered read result; holds until the next completed read
- read_valid  out  1  one-cycle strobe: read_data updated this cycle
- busy  out  1  high while zero-fill runs; requests are ignored
- fault  out  1  sticky out-of-range access flag
- io_out  out  DATA_W  memory-mapped output register

## Operation
- Select values equal to or above N_ADDR or N_DATA pick source 0.
- FSM states: CLEAR, READY. RST forces CLEAR with the fill counter at 0.
- CLEAR: writes 0 to word fill_cnt each cycle and increments fill_cnt. After word DEPTH-1 is written, the FSM moves to READY. busy=1 throughout. mem_write, mem_read and I/O accesses are ignored; read_valid stays 0.
- READY: busy=0. The address is in range when address[ADDR_W-1:DEPTH_LOG2]==0. The RAM index is address[DEPTH_LOG2-1:0].
- In-range write: RAM[index] <= selected data.
- In-range read: read_data <= RAM[index] on the next edge, and read_valid=1 for that cycle.
- mem_write and mem_read together: the write is performed, and the read returns the newly written value (write-first).
- Out-of-range access (read or write), excluding the I/O address when enabled:
  - the write is suppressed;
  - a read completes with read_data=0 and read_valid=1;
  - fault is set and stays set until RST.
- An RST asserted mid-fill, or during a pending read, restarts CLEAR from 0. It drops the pending read_valid and clears fault and io_out.

## Timing
- Reset values: read_data=0, read_valid=0, busy=1, fault=0, io_out=0.
- Read latency is 1 cycle. A request sampled at edge N produces read_data/read_valid after edge N+1.
- Back-to-back reads complete one per cycle. read_valid is asserted in every cycle that follows an accepted read.
- A write is visible to a read sampled at the next edge.
- Zero-fill takes exactly 2^DEPTH_LOG2 cycles. busy falls after the edge that writes the last word.
- The first request is accepted in the cycle busy is low.
- fault rises one edge after the offending request is sampled.

## Configuration
- MEM_IO_EN defined: the address with every ADDR_W bit set is the I/O address.
  - A write there loads io_out after 1 edge.
  - A read there returns io_in, sampled at the request edge, with normal read latency.
  - Neither access sets fault.
- MEM_IO_EN undefined: io_out is constant 0 and io_in is unused. The all-ones address is handled as any other out-of-range address, so it faults when DEPTH_LOG2 < ADDR_W.

## Test plan
- Zero-fill: with DEPTH_LOG2=4, release RST. busy=1 for exactly 16 cycles, then a read of every address returns 0x0000.
- Source select: addr_in sources hold 3/5/7/9 and mem_addr=2. Write 0xBEEF with mem_data=1, then read with mem_addr=2. RAM[7]=0xBEEF, and read_valid pulses 1 cycle after the read.
- Write-first collision: with RAM[3]=0x1111, assert write 0x2222 and read to address 3 in the same cycle. read_data=0x2222 next cycle.
- Out-of-range: with DEPTH_LOG2=4, write 0xAAAA to address 0x0010. fault=1, RAM[0] is unchanged, a read of 0x0010 returns 0x0000 with read_valid=1, and fault stays 1 until RST.
- Mid-fill reset: assert RST at fill_cnt=8 after RAM held 0x5555 everywhere. Fill restarts, busy lasts 16 more cycles, and all words read 0.
- MEM_IO_EN: write 0x00C3 to 0xFFFF, giving io_out=0x00C3. Drive io_in=0x1234 and read 0xFFFF, giving read_data=0x1234 and fault=0. Without the macro, the same write sets fault and io_out stays 0.
